// File: rtl/nes_vga_scanout_if.sv
// Read side of the PPU-to-display palette-index FIFO as seen by the VGA scanout.
// The scanout (master) issues reads; the FIFO (slave) returns registered data and an empty flag.
interface nes_vga_scanout_if #(
  parameter int IDX_W = 6
);
  logic [IDX_W-1:0] fifo_data;
  logic             fifo_empty;
  logic             fifo_re;

  modport master (input fifo_data, input fifo_empty, output fifo_re);
  modport slave  (output fifo_data, output fifo_empty, input fifo_re);
endinterface

// File: rtl/nes_vga_scanout.sv
// 640x480@60 VGA scanout of a 256x240 NES image: 2x2 pixel doubling through a one-line buffer,
// 2C02 palette lookup, and a two-stage output pipeline aligned to the timing counters.
module nes_vga_scanout #(
  parameter int               IDX_W         = 6,
  parameter int               BORDER        = 64,
  parameter logic [IDX_W-1:0] UNDERFLOW_IDX = IDX_W'(6'h0F)
) (
  input  logic              clk,
  input  logic              reset,
  nes_vga_scanout_if.master fifo,
  output logic              frame_start,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_de,
  output logic              underflow_err
);

  localparam logic [9:0] H_LAST     = 10'd799;
  localparam logic [9:0] H_ACT      = 10'd640;
  localparam logic [9:0] HS_FIRST   = 10'd656;
  localparam logic [9:0] HS_LAST    = 10'd751;
  localparam logic [9:0] V_LAST     = 10'd524;
  localparam logic [9:0] V_ACT      = 10'd480;
  localparam logic [9:0] VS_FIRST   = 10'd490;
  localparam logic [9:0] VS_LAST    = 10'd491;
  localparam logic [9:0] SPAN_LEN   = 10'd512;
  localparam logic [9:0] SLOT_FIRST = 10'(BORDER - 2);
  localparam logic [9:0] CAP_FIRST  = 10'(BORDER - 1);
  localparam logic [9:0] SPAN_FIRST = 10'(BORDER);
  localparam logic [9:0] SPAN_END   = 10'(BORDER + 512);

  localparam logic [23:0] PALETTE [64] = '{
    24'h666666, 24'h002A88, 24'h1412A7, 24'h3B00A4, 24'h5C007E, 24'h6E0040, 24'h6C0600, 24'h561D00,
    24'h333500, 24'h0B4800, 24'h005200, 24'h004F08, 24'h00404D, 24'h000000, 24'h000000, 24'h000000,
    24'hADADAD, 24'h155FD9, 24'h4240FF, 24'h7527FE, 24'hA01ACC, 24'hB71E7B, 24'hB53120, 24'h994E00,
    24'h6B6D00, 24'h388700, 24'h0C9300, 24'h008F32, 24'h007C8D, 24'h000000, 24'h000000, 24'h000000,
    24'hFFFEFF, 24'h64B0FF, 24'h9290FF, 24'hC676FF, 24'hF36AFF, 24'hFE6ECC, 24'hFE8170, 24'hEA9E22,
    24'hBCBE00, 24'h88D800, 24'h5CE430, 24'h45E082, 24'h48CDDE, 24'h4F4F4F, 24'h000000, 24'h000000,
    24'hFFFEFF, 24'hC0DFFF, 24'hD3D2FF, 24'hE8C8FF, 24'hFBC2FF, 24'hFEC4EA, 24'hFECCC5, 24'hF7D8A5,
    24'hE4E594, 24'hCFEF96, 24'hBDF4AB, 24'hB3F3CC, 24'hB5EBF2, 24'hB8B8B8, 24'h000000, 24'h000000
  };

  logic [9:0]       h_q, h_d, v_q, v_d;
  logic             de, hs_n, vs_n, in_span, fetch_line, slot, cap;
  logic [9:0]       slot_rel, cap_rel;
  logic [7:0]       lb_addr;
  logic             miss_q, uf_q;
  logic [IDX_W-1:0] new_idx, cur_idx, fetch_idx_q, lb_rd_q;
  logic [IDX_W-1:0] line_buf [256];
  logic [23:0]      s1_rgb_q, rgb_q;
  logic             s1_de_q, s1_hs_q, s1_vs_q, s1_fs_q;
  logic             de_q, hs_q, vs_q, fs_q;

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // A slot issues the FIFO read for pixel x; one cycle later (cap) the returned word is captured.
  always_comb begin
    de         = (h_q < H_ACT) && (v_q < V_ACT);
    hs_n       = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
    vs_n       = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
    in_span    = (h_q >= SPAN_FIRST) && (h_q < SPAN_END);
    fetch_line = (v_q < V_ACT) && !v_q[0];
    slot_rel   = h_q - SLOT_FIRST;
    cap_rel    = h_q - CAP_FIRST;
    slot       = fetch_line && (h_q >= SLOT_FIRST) && (slot_rel < SPAN_LEN) && !slot_rel[0];
    cap        = (v_q < V_ACT) && (h_q >= CAP_FIRST) && (cap_rel < SPAN_LEN) && !cap_rel[0];
    lb_addr    = cap_rel[8:1];
    new_idx    = miss_q ? UNDERFLOW_IDX : fifo.fifo_data;
    cur_idx    = v_q[0] ? lb_rd_q : fetch_idx_q;
  end

  assign fifo.fifo_re = slot & ~fifo.fifo_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miss_q      <= 1'b0;
      uf_q        <= 1'b0;
      fetch_idx_q <= '0;
    end else begin
      miss_q <= slot & fifo.fifo_empty;
      if (slot && fifo.fifo_empty) begin
        uf_q <= 1'b1;
      end
      if (cap && !v_q[0]) begin
        fetch_idx_q <= new_idx;
      end
    end
  end

  // Line buffer: written on fetch lines, read back (registered) on the following replay line.
  always_ff @(posedge clk) begin
    if (cap && !v_q[0]) begin
      line_buf[lb_addr] <= new_idx;
    end
    if (cap && v_q[0]) begin
      lb_rd_q <= line_buf[lb_addr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_rgb_q <= '0;
      s1_de_q  <= 1'b0;
      s1_hs_q  <= 1'b1;
      s1_vs_q  <= 1'b1;
      s1_fs_q  <= 1'b0;
      rgb_q    <= '0;
      de_q     <= 1'b0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      fs_q     <= 1'b0;
    end else begin
      s1_rgb_q <= (de && in_span) ? PALETTE[cur_idx[5:0]] : 24'h000000;
      s1_de_q  <= de;
      s1_hs_q  <= hs_n;
      s1_vs_q  <= vs_n;
      s1_fs_q  <= (h_q == 10'd0) && (v_q == 10'd0);
      rgb_q    <= s1_rgb_q;
      de_q     <= s1_de_q;
      hs_q     <= s1_hs_q;
      vs_q     <= s1_vs_q;
      fs_q     <= s1_fs_q;
    end
  end

  assign vga_r         = rgb_q[23:16];
  assign vga_g         = rgb_q[15:8];
  assign vga_b         = rgb_q[7:0];
  assign vga_de        = de_q;
  assign vga_hs        = hs_q;
  assign vga_vs        = vs_q;
  assign frame_start   = fs_q;
  assign underflow_err = uf_q;

endmodule
